// File: rtl/oit_pkg.sv
// Shared types and helpers for the keypad scanner.
package oit_pkg;

  localparam int ROWS = 4;
  localparam int COLS = 4;

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2
  } state_e;

  // Bits needed to hold the value n (at least 1).
  function automatic int oitBits(input int n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/oit_sync2.sv
// WIDTH-bit two-flop synchronizer, asynchronous active-low reset to RST_VAL.
module oit_sync2 #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] s1_q, s2_q;

  // Two back-to-back flops to settle the asynchronous input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= RST_VAL;
      s2_q <= RST_VAL;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/oit_keypad_scanner.sv
// 4x4 keypad scanner: rotating column drive, debounced press/release, hex key code.
module oit_keypad_scanner
  import oit_pkg::*;
#(
  parameter int SCAN_DIV = 4,
  parameter int DEBOUNCE = 3,
  parameter int ACTIVE   = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [ROWS-1:0] row,
  output logic [COLS-1:0] col,
  output logic [3:0]      key,
  output logic            valid,
  output logic            pressed
);

  localparam int SW = oitBits(SCAN_DIV - 1);
  localparam int DW = oitBits(DEBOUNCE);
  localparam int RW = oitBits(ROWS - 1);
  localparam int CW = oitBits(COLS - 1);
  // XOR masks converting between pin level and internal active-high form.
  localparam logic [ROWS-1:0] ROW_INV = (ACTIVE != 0) ? '0 : '1;
  localparam logic [COLS-1:0] COL_INV = (ACTIVE != 0) ? '0 : '1;

  logic [ROWS-1:0] row_s, row_act;
  logic [SW-1:0]   slot_q, slot_d;
  state_e          state_q, state_d;
  logic [COLS-1:0] col_q, col_d, col_rot;
  logic [ROWS-1:0] cand_q, cand_d;
  logic [3:0]      code_q, code_d, code_now;
  logic [DW-1:0]   mcnt_q, mcnt_d, mcnt_inc;
  logic [DW-1:0]   rcnt_q, rcnt_d, rcnt_inc;
  logic [3:0]      key_q, key_d;
  logic            valid_q, valid_d;
  logic            pressed_q, pressed_d;
  logic            sample;
  logic [RW-1:0]   row_idx;
  logic [CW-1:0]   col_idx;

  oit_sync2 #(.WIDTH(ROWS), .RST_VAL(ROW_INV)) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (row),
    .q    (row_s)
  );

  assign row_act  = row_s ^ ROW_INV;
  assign sample   = (slot_q == SW'(SCAN_DIV - 1));
  assign col_rot  = {col_q[COLS-2:0], col_q[COLS-1]};
  assign mcnt_inc = mcnt_q + 1'b1;
  assign rcnt_inc = rcnt_q + 1'b1;

  // Candidate code: lowest active row combined with the driven column.
  always_comb begin
    row_idx = '0;
    col_idx = '0;
    for (int r = ROWS - 1; r >= 0; r--) if (row_act[r]) row_idx = RW'(r);
    for (int c = COLS - 1; c >= 0; c--) if (col_q[c]) col_idx = CW'(c);
    code_now = {row_idx, col_idx};
  end

  // Scan/debounce/held state machine; all decisions are taken on sample clocks.
  always_comb begin
    state_d   = state_q;
    slot_d    = sample ? '0 : slot_q + 1'b1;
    col_d     = col_q;
    cand_d    = cand_q;
    code_d    = code_q;
    mcnt_d    = mcnt_q;
    rcnt_d    = rcnt_q;
    key_d     = key_q;
    valid_d   = 1'b0;
    pressed_d = pressed_q;
    if (sample) begin
      case (state_q)
        ST_SCAN: begin
          if (row_act == '0) begin
            col_d = col_rot;
          end else if (DEBOUNCE == 1) begin
            key_d     = code_now;
            valid_d   = 1'b1;
            pressed_d = 1'b1;
            rcnt_d    = '0;
            state_d   = ST_HELD;
          end else begin
            cand_d  = row_act;
            code_d  = code_now;
            mcnt_d  = DW'(1);
            state_d = ST_DEBOUNCE;
          end
        end
        ST_DEBOUNCE: begin
          if (row_act == cand_q) begin
            if (mcnt_inc == DW'(DEBOUNCE)) begin
              key_d     = code_q;
              valid_d   = 1'b1;
              pressed_d = 1'b1;
              mcnt_d    = '0;
              rcnt_d    = '0;
              state_d   = ST_HELD;
            end else begin
              mcnt_d = mcnt_inc;
            end
          end else begin
            mcnt_d  = '0;
            col_d   = col_rot;
            state_d = ST_SCAN;
          end
        end
        ST_HELD: begin
          // Column stays put, so keys in other columns are invisible here.
          if (row_act == '0) begin
            if (rcnt_inc == DW'(DEBOUNCE)) begin
              pressed_d = 1'b0;
              rcnt_d    = '0;
              col_d     = col_rot;
              state_d   = ST_SCAN;
            end else begin
              rcnt_d = rcnt_inc;
            end
          end else begin
            rcnt_d = '0;
          end
        end
        default: state_d = ST_SCAN;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_SCAN;
      slot_q    <= '0;
      col_q     <= COLS'(1);
      cand_q    <= '0;
      code_q    <= '0;
      mcnt_q    <= '0;
      rcnt_q    <= '0;
      key_q     <= '0;
      valid_q   <= 1'b0;
      pressed_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      slot_q    <= slot_d;
      col_q     <= col_d;
      cand_q    <= cand_d;
      code_q    <= code_d;
      mcnt_q    <= mcnt_d;
      rcnt_q    <= rcnt_d;
      key_q     <= key_d;
      valid_q   <= valid_d;
      pressed_q <= pressed_d;
    end
  end

  assign col     = col_q ^ COL_INV;
  assign key     = key_q;
  assign valid   = valid_q;
  assign pressed = pressed_q;

endmodule

// File: tb/tb_oit_keypad_scanner.sv
// Directed bench: keypad matrix model drives rows, scoreboard queues expected key codes.
module tb_oit_keypad_scanner;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  row1, col1, key1, row2, col2, key2;
  logic        valid1, pressed1, valid2, pressed2;
  logic [15:0] keys1, keys2;
  logic [3:0]  glitch1;
  int          checks = 0;
  int          errors = 0;
  int          vcount1 = 0;
  int          vcount2 = 0;
  logic [3:0]  q1[$];
  logic [3:0]  q2[$];

  always #5 clk = ~clk;

  oit_keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE(3), .ACTIVE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .row(row1), .col(col1),
    .key(key1), .valid(valid1), .pressed(pressed1)
  );

  oit_keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE(1), .ACTIVE(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .row(row2), .col(col2),
    .key(key2), .valid(valid2), .pressed(pressed2)
  );

  // Keypad matrix: a closed key (r,c) connects column c to row r.
  always_comb begin
    row1 = glitch1;
    row2 = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        if (keys1[r*4+c] && col1[c])  row1[r] = 1'b1;
        if (keys2[r*4+c] && !col2[c]) row2[r] = 1'b0;
      end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitors: every valid pulse must match the oldest queued code.
  always @(negedge clk) begin
    logic [3:0] e;
    if (rst_n === 1'b1 && valid1 === 1'b1) begin
      vcount1++;
      if (q1.size() == 0) check("spurious_valid1", 32'd1, 32'd0);
      else begin e = q1.pop_front(); check("key1", 32'(key1), 32'(e)); end
    end
    if (rst_n === 1'b1 && valid2 === 1'b1) begin
      vcount2++;
      if (q2.size() == 0) check("spurious_valid2", 32'd1, 32'd0);
      else begin e = q2.pop_front(); check("key2", 32'(key2), 32'(e)); end
    end
  end

  initial begin
    int  v0;
    bool_loop: begin end
    rst_n = 1'b0; keys1 = '0; keys2 = '0; glitch1 = '0;
    repeat (3) @(negedge clk);
    check("rst_col1", 32'(col1), 32'h1);
    check("rst_key1", 32'(key1), 32'h0);
    check("rst_valid1", 32'(valid1), 32'h0);
    check("rst_pressed1", 32'(pressed1), 32'h0);
    check("rst_col2", 32'(col2), 32'hE);

    // Idle scan: 4 clocks per column, starting at column 0.
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      check("scan_col", 32'(col1), 32'(4'b0001 << ((k / 4) % 4)));
      @(negedge clk);
    end
    check("idle_no_valid", 32'(vcount1), 32'd0);

    // Press key A (row2, col2).
    keys1[10] = 1'b1; q1.push_back(4'hA);
    v0 = vcount1;
    for (int i = 0; i < 200 && vcount1 == v0; i++) begin @(negedge clk); #1; end
    check("valid_A_seen", 32'(vcount1 != v0), 32'd1);
    check("pressed_A", 32'(pressed1), 32'd1);
    check("col_A", 32'(col1), 32'h4);
    repeat (40) @(negedge clk);
    check("single_pulse_A", 32'(vcount1 - v0), 32'd1);
    check("col_held_A", 32'(col1), 32'h4);
    check("key_retain_A", 32'(key1), 32'hA);

    // Release: pressed falls on the same edge col moves on.
    keys1[10] = 1'b0;
    for (int i = 0; i < 200 && pressed1 !== 1'b0; i++) @(negedge clk);
    check("release_A", 32'(pressed1), 32'd0);
    check("col_after_release", 32'(col1), 32'h8);

    // Rows 1 and 3 in column 1: lowest row wins -> key 5.
    keys1[5] = 1'b1; keys1[13] = 1'b1; q1.push_back(4'h5);
    v0 = vcount1;
    for (int i = 0; i < 200 && vcount1 == v0; i++) begin @(negedge clk); #1; end
    check("valid_5_seen", 32'(vcount1 != v0), 32'd1);
    // Second key in another column while held must be ignored.
    keys1[7] = 1'b1;
    repeat (60) @(negedge clk);
    check("held_ignore", 32'(vcount1 - v0), 32'd1);
    check("key_retain_5", 32'(key1), 32'h5);
    keys1 = '0;
    for (int i = 0; i < 200 && pressed1 !== 1'b0; i++) @(negedge clk);
    check("release_5", 32'(pressed1), 32'd0);

    // One-sample bounce in column 2 must be discarded.
    v0 = vcount1;
    begin
      logic [3:0] prev;
      prev = col1;
      for (int i = 0; i < 100 && !(prev != 4'h4 && col1 == 4'h4); i++) begin
        prev = col1; @(negedge clk);
      end
    end
    check("bounce_sync", 32'(col1), 32'h4);
    glitch1 = 4'b0100;
    repeat (4) @(negedge clk);
    glitch1 = 4'b0000;
    repeat (3) @(negedge clk);
    check("bounce_col_hold", 32'(col1), 32'h4);
    @(negedge clk);
    check("bounce_col_adv", 32'(col1), 32'h8);
    repeat (20) @(negedge clk);
    check("bounce_no_valid", 32'(vcount1 - v0), 32'd0);

    // Asynchronous reset while held.
    keys1[15] = 1'b1; q1.push_back(4'hF);
    v0 = vcount1;
    for (int i = 0; i < 200 && vcount1 == v0; i++) begin @(negedge clk); #1; end
    check("valid_F_seen", 32'(vcount1 != v0), 32'd1);
    repeat (5) @(negedge clk);
    @(posedge clk); #2;
    rst_n = 1'b0; #1;
    check("async_col", 32'(col1), 32'h1);
    check("async_key", 32'(key1), 32'h0);
    check("async_valid", 32'(valid1), 32'h0);
    check("async_pressed", 32'(pressed1), 32'h0);
    keys1 = '0;
    @(negedge clk); rst_n = 1'b1;
    v0 = vcount1;
    repeat (30) @(negedge clk);
    check("restart_col", 32'(col1), 32'h8);
    check("restart_no_valid", 32'(vcount1 - v0), 32'd0);

    // ACTIVE=0, DEBOUNCE=1: single-sample acceptance of key 0.
    keys2[0] = 1'b1; q2.push_back(4'h0);
    v0 = vcount2;
    for (int i = 0; i < 200 && vcount2 == v0; i++) begin @(negedge clk); #1; end
    check("valid2_seen", 32'(vcount2 != v0), 32'd1);
    check("pressed2", 32'(pressed2), 32'd1);
    check("col2_held", 32'(col2), 32'hE);

    check("q1_drained", 32'(q1.size()), 32'd0);
    check("q2_drained", 32'(q2.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
